// File: rtl/dma_ram_pkg.sv
// Shared types and helpers for the DMA buffer RAM controller.
// Holds the controller state encoding, legal read-latency range and parity helper.
package dma_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        CLR  = 2'd3
    } state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;
    localparam int PAR_MAX_W    = 64;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dma_ram_array.sv
// Plain synchronous storage: one write port, one read port with a READ_LAT-deep output register.
// Read data and its valid appear READ_LAT edges after rd_en; no backpressure, output holds between reads.
module dma_ram_array #(
    parameter int W        = 8,
    parameter int DEPTH    = 32768,
    parameter int IDX_W    = 15,
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [W-1:0]     wr_dat,
    input  logic             rd_en,
    input  logic             rd_zero,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W-1:0]     rd_dat,
    output logic             rd_vld
);

    logic [W-1:0]        mem [DEPTH];
    logic [W-1:0]        pipe [READ_LAT];
    logic [READ_LAT-1:0] vld;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    // Each stage loads only when a read moves through it, so the output holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            vld[0] <= rd_en;
            if (rd_en) begin
                pipe[0] <= rd_zero ? '0 : mem[rd_idx];
            end
            for (int i = 1; i < READ_LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    assign rd_dat = pipe[READ_LAT-1];
    assign rd_vld = vld[READ_LAT-1];

endmodule

// File: rtl/dma_ram_ctrl.sv
// Single-port DMA buffer RAM with req/done handshake, hardware clear and range error; optional DMA_RAM_PARITY_EN.
// Write done 1 cycle, read done READ_LAT cycles after accept, clear DEPTH+1 cycles; ready low while busy.
module dma_ram_ctrl
    import dma_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 32768,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef DMA_RAM_PARITY_EN
    input  logic              perr_inject,
    output logic              perr,
`endif
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_done,
    output logic              wr_done,
    output logic              clr_done,
    output logic              ready,
    output logic              err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMA_RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
        $error("dma_ram_ctrl: READ_LAT must be 1 or 2");
    end

    state_t            state, state_nxt;
    logic              rd_acc, wr_acc, clr_acc;
    logic              in_range;
    logic              oor_q;
    logic              wr_done_q;
    logic              clr_done_q;
    logic [IDX_W-1:0]  clr_cnt;
    logic              arr_wr_en;
    logic [IDX_W-1:0]  arr_wr_idx;
    logic [MEM_W-1:0]  arr_wr_dat;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  arr_rd_dat;
    logic              arr_rd_vld;

    // Unsigned compare at full address width, widened so DEPTH == 2**ADDR_W still fits.
    assign in_range = ({1'b0, addr} < DEPTH_LIM);

    always_comb begin
        state_nxt = state;
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        clr_acc   = 1'b0;
        case (state)
            IDLE: begin
                if (clr) begin
                    clr_acc   = 1'b1;
                    state_nxt = CLR;
                end else if (rd_req) begin
                    rd_acc    = 1'b1;
                    state_nxt = RD;
                end else if (wr_req) begin
                    wr_acc    = 1'b1;
                    state_nxt = WR;
                end
            end
            RD:      if (arr_rd_vld) state_nxt = IDLE;
            WR:      state_nxt = IDLE;
            CLR:     if (clr_done_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            oor_q      <= 1'b0;
            wr_done_q  <= 1'b0;
            clr_done_q <= 1'b0;
            clr_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            wr_done_q  <= wr_acc;
            clr_done_q <= (state == CLR) && !clr_done_q && (clr_cnt == LAST_IDX);
            if (rd_acc || wr_acc) begin
                oor_q <= !in_range;
            end
            if (clr_acc) begin
                clr_cnt <= '0;
            end else if (state == CLR && !clr_done_q) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

`ifdef DMA_RAM_PARITY_EN
    assign wr_word = {calc_parity(PAR_MAX_W'(wr_data)) ^ perr_inject, wr_data};
`else
    assign wr_word = wr_data;
`endif

    // Memory is written on the accept edge itself; the clear sweep owns the port while in CLR.
    assign arr_wr_en  = (wr_acc && in_range) || (state == CLR && !clr_done_q);
    assign arr_wr_idx = (state == CLR) ? clr_cnt : addr[IDX_W-1:0];
    assign arr_wr_dat = (state == CLR) ? '0 : wr_word;

    dma_ram_array #(
        .W        (MEM_W),
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .READ_LAT (READ_LAT)
    ) u_array (
        .clk     (clk),
        .rst_n   (RST),
        .wr_en   (arr_wr_en),
        .wr_idx  (arr_wr_idx),
        .wr_dat  (arr_wr_dat),
        .rd_en   (rd_acc),
        .rd_zero (!in_range),
        .rd_idx  (addr[IDX_W-1:0]),
        .rd_dat  (arr_rd_dat),
        .rd_vld  (arr_rd_vld)
    );

    assign rd_data  = arr_rd_dat[DATA_W-1:0];
    assign rd_done  = arr_rd_vld;
    assign wr_done  = wr_done_q;
    assign clr_done = clr_done_q;
    assign ready    = (state == IDLE);
    assign err      = oor_q && (rd_done || wr_done);

`ifdef DMA_RAM_PARITY_EN
    assign perr = rd_done && !oor_q &&
                  (arr_rd_dat[DATA_W] != calc_parity(PAR_MAX_W'(rd_data)));
`endif

endmodule

// File: tb/tb_dma_ram_ctrl.sv
// Directed self-checking bench for dma_ram_ctrl; read latency 2 when DMA_RAM_PARITY_EN is defined.
module tb_dma_ram_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 32768;
`ifdef DMA_RAM_PARITY_EN
    localparam int RL = 2;
`else
    localparam int RL = 1;
`endif

    logic          clk = 1'b0;
    logic          RST;
    logic          rd_req, wr_req, clr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_done, wr_done, clr_done, ready, err;
`ifdef DMA_RAM_PARITY_EN
    logic          perr_inject, perr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_ram_ctrl #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .READ_LAT (RL)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .clr         (clr),
        .addr        (addr),
        .wr_data     (wr_data),
`ifdef DMA_RAM_PARITY_EN
        .perr_inject (perr_inject),
        .perr        (perr),
`endif
        .rd_data     (rd_data),
        .rd_done     (rd_done),
        .wr_done     (wr_done),
        .clr_done    (clr_done),
        .ready       (ready),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the controller idle; returns at a negedge, idle again.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic inj, input logic exp_err);
        addr    = a;
        wr_data = d;
        wr_req  = 1'b1;
`ifdef DMA_RAM_PARITY_EN
        perr_inject = inj;
`endif
        @(negedge clk);
        chk("wr_done_pulse", wr_done, 1);
        chk("wr_err", err, exp_err);
        chk("wr_busy", ready, 0);
        wr_req = 1'b0;
`ifdef DMA_RAM_PARITY_EN
        perr_inject = 1'b0;
`endif
        @(negedge clk);
        chk("wr_done_end", wr_done, 0);
        chk("wr_ready", ready, 1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                           input logic exp_err, input logic exp_perr);
        addr   = a;
        rd_req = 1'b1;
        @(negedge clk);
        for (int k = 1; k < RL; k++) begin
            chk("rd_wait_done", rd_done, 0);
            chk("rd_wait_busy", ready, 0);
            @(negedge clk);
        end
        chk("rd_done_pulse", rd_done, 1);
        chk("rd_data", rd_data, exp_d);
        chk("rd_err", err, exp_err);
`ifdef DMA_RAM_PARITY_EN
        chk("rd_perr", perr, exp_perr);
`endif
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_done_end", rd_done, 0);
        chk("rd_ready", ready, 1);
    endtask

    initial begin
        int n;
        int seen_rd;

        RST     = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        clr     = 1'b0;
        addr    = '0;
        wr_data = '0;
`ifdef DMA_RAM_PARITY_EN
        perr_inject = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_done", rd_done, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_err", err, 0);
        RST = 1'b1;
        @(negedge clk);

        // Basic write then read back.
        do_write(16'd5, 8'hA5, 1'b0, 1'b0);
        do_read(16'd5, 8'hA5, 1'b0, 1'b0);

        // Simultaneous read and write: read wins, write follows after an idle cycle.
        do_write(16'd3, 8'h77, 1'b0, 1'b0);
        addr    = 16'd3;
        wr_data = 8'h3C;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        @(negedge clk);
        for (int k = 1; k < RL; k++) @(negedge clk);
        chk("both_rd_done", rd_done, 1);
        chk("both_no_wr_yet", wr_done, 0);
        chk("both_rd_old_data", rd_data, 8'h77);
        rd_req = 1'b0;
        @(negedge clk);
        chk("both_idle_ready", ready, 1);
        chk("both_idle_rd_done", rd_done, 0);
        @(negedge clk);
        chk("both_wr_done", wr_done, 1);
        chk("both_wr_busy", ready, 0);
        chk("both_rd_done_once", rd_done, 0);
        wr_req = 1'b0;
        @(negedge clk);
        chk("both_wr_done_once", wr_done, 0);
        do_read(16'd3, 8'h3C, 1'b0, 1'b0);

        // Out-of-range write and reads.
        do_write(16'd0, 8'h5A, 1'b0, 1'b0);
        do_write(16'd32768, 8'h99, 1'b0, 1'b1);
        do_read(16'd0, 8'h5A, 1'b0, 1'b0);
        do_read(16'd40000, 8'h00, 1'b1, 1'b0);
        do_read(16'd32767, 8'h00, 1'b0, 1'b0);

        // Full clear with a read request pending throughout.
        do_write(16'd0, 8'hFF, 1'b0, 1'b0);
        do_write(16'd1, 8'hFF, 1'b0, 1'b0);
        do_write(16'd32767, 8'hFF, 1'b0, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        n       = 1;
        seen_rd = 0;
        addr    = 16'd0;
        rd_req  = 1'b1;
        chk("clr_busy", ready, 0);
        while (!clr_done && n < 40000) begin
            if (rd_done) seen_rd++;
            @(negedge clk);
            n++;
        end
        chk("clr_cycles", n, DEPTH + 1);
        chk("clr_done_pulse", clr_done, 1);
        chk("clr_rd_ignored", seen_rd, 0);
        clr    = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        chk("clr_done_end", clr_done, 0);
        chk("clr_ready", ready, 1);
        chk("clr_no_rd_done", rd_done, 0);
        do_read(16'd0, 8'h00, 1'b0, 1'b0);
        do_read(16'd1, 8'h00, 1'b0, 1'b0);
        do_read(16'd32767, 8'h00, 1'b0, 1'b0);

        // Reset during clear leaves memory partially cleared.
        do_write(16'd98, 8'h11, 1'b0, 1'b0);
        do_write(16'd200, 8'h22, 1'b0, 1'b0);
        do_write(16'd32767, 8'hFF, 1'b0, 1'b0);
        do_read(16'd200, 8'h22, 1'b0, 1'b0);
        clr = 1'b1;
        @(posedge clk);
        repeat (99) @(posedge clk);
        #2 RST = 1'b0;
        #1;
        chk("arst_ready", ready, 1);
        chk("arst_clr_done", clr_done, 0);
        chk("arst_rd_data", rd_data, 0);
        chk("arst_err", err, 0);
        clr = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_no_clr_done", clr_done, 0);
        chk("arst_idle", ready, 1);
        do_read(16'd0, 8'h00, 1'b0, 1'b0);
        do_read(16'd98, 8'h00, 1'b0, 1'b0);
        do_read(16'd200, 8'h22, 1'b0, 1'b0);
        do_read(16'd32767, 8'hFF, 1'b0, 1'b0);

`ifdef DMA_RAM_PARITY_EN
        // Injected parity error is flagged; a clean write is not.
        do_write(16'd7, 8'h3C, 1'b1, 1'b0);
        do_read(16'd7, 8'h3C, 1'b0, 1'b1);
        do_write(16'd7, 8'h3C, 1'b0, 1'b0);
        do_read(16'd7, 8'h3C, 1'b0, 1'b0);
        do_read(16'd40000, 8'h00, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
